// File: rtl/acc_pkg.sv
// Shared constants, state encoding and helpers for the frame accumulator.
package acc_pkg;

  localparam int DEFAULT_COUNT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Ceiling log2, usable in parameter defaults on tools lacking $clog2 there.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Modulo-COUNT counter of terms accepted in the current frame.
module frame_counter
  import acc_pkg::*;
#(
  parameter int COUNT = DEFAULT_COUNT
) (
  input  logic clk_i,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic first,
  output logic last
);

  localparam int CW = clog2(COUNT);
  localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= last ? '0 : r_cnt + CW'(1);
    end
  end

  assign first = (r_cnt == '0);
  assign last  = (r_cnt == LAST_CNT);

endmodule

// File: rtl/sum_accumulator.sv
// Reduces COUNT consecutive valid terms into one frame total, emitted as a
// single-cycle pulse with no dead cycles between frames.
`ifndef WIDTH
`define WIDTH 8
`endif

module sum_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH     = `WIDTH,
  parameter int COUNT     = DEFAULT_COUNT,
  parameter int ACC_WIDTH = WIDTH + clog2(COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 valid_i,
  input  logic                 clear_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  logic                 w_take;
  logic                 w_first;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_term;
  state_e               w_state;

  logic [ACC_WIDTH-1:0] r_acc_q;
  logic [ACC_WIDTH-1:0] r_acc_out;
  logic                 r_valid;

  // A term arriving together with clear is discarded.
  assign w_take = valid_i & ~clear_i;
  assign w_term = ACC_WIDTH'(data_i);

  frame_counter #(
    .COUNT(COUNT)
  ) u_frame_counter (
    .clk_i(clk_i),
    .rstn (rstn),
    .inc  (w_take),
    .clr  (clear_i),
    .first(w_first),
    .last (w_last)
  );

  assign w_state = w_first ? ST_IDLE : ST_ACCUM;

  // NOTE: the accumulator is an ordinary register, not a memory, so it is reset
  // along with the rest of the datapath.
  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      r_acc_q   <= '0;
      r_acc_out <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_take) begin
        if (w_last) begin
          r_acc_out <= r_acc_q + w_term;
          r_valid   <= 1'b1;
        end else if (w_first) begin
          r_acc_q <= w_term;
        end else begin
          r_acc_q <= r_acc_q + w_term;
        end
      end
    end
  end

  assign acc_o   = r_acc_out;
  assign valid_o = r_valid;
  // Decoded from the counter register only; no input reaches an output.
  assign busy_o  = (w_state == ST_ACCUM);

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: frame table plus hand sequences, scoreboarded totals.
module tb_sum_accumulator;

  logic       clk;
  logic       rstn;
  logic [7:0] data;
  logic       valid;
  logic       clear;

  logic [9:0] acc_o;
  logic       valid_o;
  logic       busy_o;
  logic [7:0] acc8_o;
  logic       valid8_o;
  logic       busy8_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;

  logic [9:0] exp_q[$];
  logic [9:0] model_acc = '0;
  logic       prev_valid = 1'b0;
  logic       mon_en = 1'b0;

  sum_accumulator #(.WIDTH(8), .COUNT(4)) dut (
    .clk_i  (clk),
    .rstn   (rstn),
    .data_i (data),
    .valid_i(valid),
    .clear_i(clear),
    .acc_o  (acc_o),
    .valid_o(valid_o),
    .busy_o (busy_o)
  );

  sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(8)) dut8 (
    .clk_i  (clk),
    .rstn   (rstn),
    .data_i (data),
    .valid_i(valid),
    .clear_i(clear),
    .acc_o  (acc8_o),
    .valid_o(valid8_o),
    .busy_o (busy8_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic c, input logic [7:0] d);
    valid = v;
    clear = c;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  // Scoreboard: every pulse must match the oldest pending total; otherwise
  // acc_o must hold the last total.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o) begin
        n_pulse++;
        check("pulse_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", valid_o, 0);
        end else begin
          model_acc = exp_q.pop_front();
          check("frame_total", acc_o, model_acc);
        end
      end else begin
        check("acc_hold", acc_o, model_acc);
      end
      prev_valid = valid_o;
      if (!rstn) begin
        model_acc = '0;
        exp_q.delete();
      end
    end
  end

  typedef struct {
    logic [7:0] terms[4];
    int         gap;
    logic [9:0] exp;
    logic [7:0] exp8;
  } frame_t;

  frame_t tbl[5];

  function automatic frame_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input int gap, input logic [9:0] exp,
                                input logic [7:0] exp8);
    frame_t f;
    f.terms[0] = a;
    f.terms[1] = b;
    f.terms[2] = c;
    f.terms[3] = d;
    f.gap      = gap;
    f.exp      = exp;
    f.exp8     = exp8;
    return f;
  endfunction

  initial begin
    tbl[0] = mk(8'd10,  8'd20,  8'd30,  8'd40,  0, 10'd100,  8'd100);
    tbl[1] = mk(8'd5,   8'd6,   8'd7,   8'd8,   3, 10'd26,   8'd26);
    tbl[2] = mk(8'd255, 8'd255, 8'd255, 8'd255, 0, 10'd1020, 8'd252);
    tbl[3] = mk(8'd1,   8'd1,   8'd1,   8'd1,   0, 10'd4,    8'd4);
    tbl[4] = mk(8'd1,   8'd1,   8'd1,   8'd1,   0, 10'd4,    8'd4);

    rstn  = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    data  = '0;

    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    mon_en = 1'b1;
    rstn   = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0);
    check("idle_acc", acc_o, 0);
    check("idle_busy", busy_o, 0);

    // Frame table: back-to-back, gapped, wrapping and consecutive frames.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back(tbl[r].exp);
        step(1'b1, 1'b0, tbl[r].terms[k]);
        if (k < 3) begin
          check("busy_mid", busy_o, 1);
          for (int g = 0; g < tbl[r].gap; g++) begin
            step(1'b0, 1'b0, 8'd0);
            check("busy_gap", busy_o, 1);
          end
        end
      end
      check("end_valid", valid_o, 1);
      check("end_acc", acc_o, tbl[r].exp);
      check("end_busy", busy_o, 0);
      check("wrap_valid", valid8_o, 1);
      check("wrap_acc", acc8_o, tbl[r].exp8);
      if (r == 0) begin
        step(1'b0, 1'b0, 8'd0);
        check("post_valid", valid_o, 0);
        check("post_acc", acc_o, 100);
      end
    end

    // Clear aborts the frame and discards the term sampled with it.
    step(1'b1, 1'b0, 8'd1);
    step(1'b1, 1'b0, 8'd2);
    check("clr_busy_before", busy_o, 1);
    step(1'b1, 1'b1, 8'd3);
    check("clr_busy_after", busy_o, 0);
    check("clr_valid", valid_o, 0);
    check("clr_acc", acc_o, 4);
    step(1'b1, 1'b0, 8'd1);
    step(1'b1, 1'b0, 8'd2);
    step(1'b1, 1'b0, 8'd3);
    exp_q.push_back(10'd10);
    step(1'b1, 1'b0, 8'd4);
    check("clr_frame_valid", valid_o, 1);
    check("clr_frame_acc", acc_o, 10);

    // Reset mid-frame drops the partial frame without a pulse.
    step(1'b1, 1'b0, 8'd9);
    step(1'b1, 1'b0, 8'd9);
    check("pre_rst_busy", busy_o, 1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_acc", acc_o, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(10'd8);
      step(1'b1, 1'b0, 8'd2);
    end
    check("post_rst_valid", valid_o, 1);
    check("post_rst_acc", acc_o, 8);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0);
    check("pending", exp_q.size(), 0);
    check("pulse_count", n_pulse, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Streaming accumulator directly downstream of the registered adder stage. Consumes its `sum_o`/`valid_o` stream, adds `COUNT` consecutive valid sums into a widened accumulator, and emits each completed frame total as a one-cycle-valid result with no dead cycles between frames. It is the reduction stage that turns per-element sums into one frame value.

## Interface
- `WIDTH`, default `` `WIDTH ``: input term width, unsigned.
- `COUNT`, default 4: terms per frame, at least 2.
- `ACC_WIDTH`, default `WIDTH + $clog2(COUNT)`: accumulator and result width. The default is overflow-free.
- `clk_i`  input  1: single clock. Everything is registered on the rising edge.
- `rstn`  input  1: synchronous, active-low reset.
- `data_i`  input  WIDTH: term from the upstream adder stage.
- `valid_i`  input  1: `data_i` is valid this cycle.
- `clear_i`  input  1: abort the current frame.
- `acc_o`  output  ACC_WIDTH: last completed frame total, held.
- `valid_o`  output  1: one-cycle pulse when `acc_o` updates.
- `busy_o`  output  1: a frame is partially accumulated.

## Operation
- States: IDLE (`cnt == 0`) and ACCUM (`0 < cnt < COUNT`). `busy_o` is high exactly in ACCUM.
- `cnt` is a `$clog2(COUNT)`-bit counter of terms accepted in the current frame. Internal accumulator is `acc_q`.
- Term handling is by count:
  - First term of a frame: `acc_q <= zero-extend(data_i)`. No add to a stale value.
  - Middle terms: `acc_q <= acc_q + data_i`, `cnt++`.
  - COUNT-th term: `acc_o <= acc_q + data_i`, `valid_o <= 1`, `cnt <= 0`, state goes to IDLE.
- Arithmetic is unsigned, zero-extended, and wraps modulo `2^ACC_WIDTH` if the user narrows `ACC_WIDTH`. There is no saturation.
- `valid_i` low: `cnt` and `acc_q` hold. Gaps of any length are allowed.
- `clear_i` high: `cnt <= 0`, state goes to IDLE. Any term presented in the same cycle is discarded. `acc_o` keeps its old value and `valid_o` stays 0.
- There is no backpressure. Upstream cannot stall, so every accepted term is consumed.

## Timing
- Reset (`rstn` low at an edge): `acc_o = 0`, `valid_o = 0`, `busy_o = 0`, `cnt = 0`, `acc_q = 0`.
- Reset in mid-frame drops the partial frame and produces no output pulse.
- Latency: `valid_o` and the new `acc_o` appear the cycle after the edge that samples the COUNT-th valid term.
- `valid_o` is high for exactly one cycle per completed frame. `acc_o` is stable between pulses.
- Back-to-back frames:
  - A term in the cycle after a completing term is the first term of the next frame.
  - Two completions can pulse `valid_o` at most once every `COUNT` cycles.
- `busy_o` rises the cycle after the first term of a frame is sampled.
- `busy_o` falls the cycle after the completing term or the clear is sampled.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `acc_pkg` holds:
  - the default `COUNT` constant;
  - the state enum (IDLE, ACCUM);
  - a `clog2` helper for tools without `$clog2` in parameter context.
- Sub-module `frame_counter` provides the modulo-`COUNT` term counter:
  - inputs: `inc`, `clr`;
  - outputs: `first`, `last`.
- The top level keeps the datapath: `acc_q`, output register, and the `valid_o` flop.

## Test plan
All scenarios use WIDTH=8, COUNT=4 (ACC_WIDTH=10).

1. Hold `rstn` low for 2 cycles -> `acc_o == 0`, `valid_o == 0`, `busy_o == 0`. Release, then leave `valid_i` low for 5 cycles -> no change.
2. Present 10, 20, 30, 40 on consecutive cycles -> the cycle after 40 shows `valid_o == 1` and `acc_o == 100`. The following cycle shows `valid_o == 0` with `acc_o` still 100.
3. Present terms 5, 6, 7, 8 with 3 idle cycles between each -> exactly one `valid_o` pulse with `acc_o == 26`. `busy_o` stays high through the gaps.
4. Present 255 four times -> `acc_o == 1020`. Repeat with `ACC_WIDTH=8` -> `acc_o == 252` (wrap).
5. Present 1, 2, then `clear_i` together with 3, then 1, 2, 3, 4:
   - no pulse is produced for the aborted frame;
   - one pulse with `acc_o == 10`;
   - the term 3 sampled with the clear is not counted.
6. Present eight consecutive terms of value 1 -> pulses after the 4th and 8th terms, each with `acc_o == 4`. Then feed 9, 9 and pull `rstn` low for one cycle -> `busy_o == 0` and no pulse. The next four terms of 2 give `acc_o == 8`.
